// File: rtl/calc_job_ctrl.sv
// calc_job_ctrl: sequences one calculation job on a small processor.
// It loads the operands and the opcode into dmem, holds the core in reset
// for two cycles, releases it, and snoops its stores for the result word.
// Optional watchdog: define CALC_TIMEOUT_EN to bound the RUN phase to
// TIMEOUT_CYCLES cycles. Without the macro, RUN waits for the result store
// indefinitely and timeout is tied low.
module calc_job_ctrl #(
  parameter logic [31:0] RESULT_ADDR    = 32'h0000000C,
  parameter int unsigned TIMEOUT_CYCLES = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [31:0] opcode,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [31:0] result,
  output logic        cpu_reset,
  output logic        mem_sel,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        cpu_memwrite,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata
);

  typedef enum logic [2:0] {StIdle, StLoad, StHold, StRun, StFin} state_e;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic [31:0] opcode_q, opcode_d;
  logic [31:0] result_q, result_d;
  logic        hit;

  // Processor store to the result word.
  assign hit = cpu_memwrite && (cpu_addr == RESULT_ADDR);

`ifdef CALC_TIMEOUT_EN
  logic [31:0] run_cnt_q, run_cnt_d;
  logic        timeout_q, timeout_d;
  logic        expired;

  // Last budgeted RUN cycle: the counter holds the number of RUN cycles already spent.
  assign expired = (run_cnt_q == 32'(TIMEOUT_CYCLES - 1));
`endif

  // Next-state logic: phase sequencing, operand latch and result capture.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    opcode_d = opcode_q;
    result_d = result_q;
`ifdef CALC_TIMEOUT_EN
    timeout_d = timeout_q;
    run_cnt_d = (state_q == StRun) ? run_cnt_q + 32'd1 : 32'd0;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StLoad;
          cnt_d    = 2'd0;
          op_a_d   = op_a;
          op_b_d   = op_b;
          opcode_d = opcode;
`ifdef CALC_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
        end
      end
      StLoad: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d = StHold;
          cnt_d   = 2'd0;
        end
      end
      StHold: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd1) begin
          state_d = StRun;
          cnt_d   = 2'd0;
        end
      end
      StRun: begin
        // A matching store wins over an expiring budget in the same cycle.
        if (hit) begin
          result_d = cpu_wdata;
          state_d  = StFin;
        end
`ifdef CALC_TIMEOUT_EN
        else if (expired) begin
          timeout_d = 1'b1;
          state_d   = StFin;
        end
`endif
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= 2'd0;
      op_a_q   <= 32'd0;
      op_b_q   <= 32'd0;
      opcode_q <= 32'd0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      opcode_q <= opcode_d;
      result_q <= result_d;
    end
  end

`ifdef CALC_TIMEOUT_EN
  // Watchdog registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      run_cnt_q <= 32'd0;
      timeout_q <= 1'b0;
    end else begin
      run_cnt_q <= run_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  // LOAD drives the four dmem words in order; the bus is zero elsewhere.
  always_comb begin
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    if (state_q == StLoad) begin
      unique case (cnt_q)
        2'd0: begin
          mem_addr  = 32'h0;
          mem_wdata = op_a_q;
        end
        2'd1: begin
          mem_addr  = 32'h4;
          mem_wdata = op_b_q;
        end
        2'd2: begin
          mem_addr  = 32'h8;
          mem_wdata = opcode_q;
        end
        default: begin
          mem_addr  = RESULT_ADDR;
          mem_wdata = 32'd0;
        end
      endcase
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StFin);
  assign cpu_reset = (state_q != StRun);
  assign mem_sel   = (state_q == StLoad);
  assign mem_we    = (state_q == StLoad);
  assign result    = result_q;

endmodule

// File: tb/tb_calc_job_ctrl.sv
// Bench for calc_job_ctrl: directed scenarios plus randomized traffic, with a
// cycle-count job model compared against the DUT every cycle.
module tb_calc_job_ctrl;

  localparam logic [31:0] RA = 32'h0000000C;
  localparam int unsigned TO = 100;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] op_a, op_b, opcode;
  logic        busy, done, timeout, cpu_reset, mem_sel, mem_we;
  logic [31:0] result, mem_addr, mem_wdata;
  logic        cpu_memwrite;
  logic [31:0] cpu_addr, cpu_wdata;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  calc_job_ctrl #(
    .RESULT_ADDR   (RA),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op_a        (op_a),
    .op_b        (op_b),
    .opcode      (opcode),
    .busy        (busy),
    .done        (done),
    .timeout     (timeout),
    .result      (result),
    .cpu_reset   (cpu_reset),
    .mem_sel     (mem_sel),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .cpu_memwrite(cpu_memwrite),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Job model: m_t counts cycles since the start was accepted (1..4 load,
  // 5..6 hold, 7.. run); m_fin marks the one-cycle completion beat.
  bit          m_active = 1'b0;
  bit          m_fin = 1'b0;
  int          m_t = 0;
  logic [31:0] m_a = '0, m_b = '0, m_op = '0;
  logic [31:0] m_result = '0;
  bit          m_timeout = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_active  <= 1'b0;
      m_fin     <= 1'b0;
      m_t       <= 0;
      m_result  <= '0;
      m_timeout <= 1'b0;
    end else if (!m_active) begin
      if (start) begin
        m_active  <= 1'b1;
        m_fin     <= 1'b0;
        m_t       <= 1;
        m_a       <= op_a;
        m_b       <= op_b;
        m_op      <= opcode;
        m_timeout <= 1'b0;
      end
    end else if (m_fin) begin
      m_active <= 1'b0;
      m_fin    <= 1'b0;
    end else if (m_t >= 7) begin
      if (cpu_memwrite && cpu_addr == RA) begin
        m_result <= cpu_wdata;
        m_fin    <= 1'b1;
      end
`ifdef CALC_TIMEOUT_EN
      else if (m_t - 6 == int'(TO)) begin
        m_timeout <= 1'b1;
        m_fin     <= 1'b1;
      end
`endif
      else begin
        m_t <= m_t + 1;
      end
    end else begin
      m_t <= m_t + 1;
    end
  end

  logic        e_load, e_run;
  logic [31:0] e_addr, e_wdata;

  // Per-cycle comparison, mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      e_load  = m_active && !m_fin && (m_t <= 4);
      e_run   = m_active && !m_fin && (m_t >= 7);
      e_addr  = '0;
      e_wdata = '0;
      if (e_load) begin
        e_addr = (m_t == 4) ? RA : 32'((m_t - 1) * 4);
        case (m_t)
          1:       e_wdata = m_a;
          2:       e_wdata = m_b;
          3:       e_wdata = m_op;
          default: e_wdata = '0;
        endcase
      end
      check("busy", busy, m_active);
      check("done", done, m_fin);
      check("timeout", timeout, m_timeout);
      check("result", result, m_result);
      check("cpu_reset", cpu_reset, !e_run);
      check("mem_sel", mem_sel, e_load);
      check("mem_we", mem_we, e_load);
      check("mem_addr", mem_addr, e_addr);
      check("mem_wdata", mem_wdata, e_wdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic cpu_idle();
    cpu_memwrite = 1'b0;
    cpu_addr     = '0;
    cpu_wdata    = '0;
  endtask

  task automatic cpu_wr(input logic [31:0] a, input logic [31:0] d);
    cpu_memwrite = 1'b1;
    cpu_addr     = a;
    cpu_wdata    = d;
  endtask

  logic [31:0] lit_addr [4];
  logic [31:0] lit_data [4];

  initial begin
    reset = 1'b1;
    start = 1'b0;
    op_a = '0;
    op_b = '0;
    opcode = '0;
    cpu_idle();
    tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_cpu_reset", cpu_reset, 1'b1);
    check("rst_result", result, 32'd0);
    check("rst_mem_sel", mem_sel, 1'b0);

    // Basic add job, result stored on the first RUN cycle.
    lit_addr = '{32'h0, 32'h4, 32'h8, 32'hC};
    lit_data = '{32'd10, 32'd5, 32'd1, 32'd0};
    start = 1'b1; op_a = 32'd10; op_b = 32'd5; opcode = 32'd1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("load_addr", mem_addr, lit_addr[i]);
      check("load_data", mem_wdata, lit_data[i]);
      check("load_we", mem_we, 1'b1);
      tick();
    end
    tick();
    tick();
    cpu_wr(32'hC, 32'd15);
    @(negedge clk);
    check("run1_cpu_reset", cpu_reset, 1'b0);
    tick();
    cpu_idle();
    @(negedge clk);
    check("j1_done", done, 1'b1);
    check("j1_result", result, 32'd15);
    check("j1_timeout", timeout, 1'b0);
    tick();
    @(negedge clk);
    check("j1_done_low", done, 1'b0);

    // Multiply job: store to 0x8 ignored, store to 0xC captured.
    start = 1'b1; op_a = 32'd4; op_b = 32'd6; opcode = 32'd3;
    tick();
    start = 1'b0;
    repeat (6) tick();
    cpu_wr(32'h8, 32'd24);
    tick();
    cpu_wr(32'hC, 32'd24);
    @(negedge clk);
    check("j2_still_run", done, 1'b0);
    tick();
    cpu_idle();
    @(negedge clk);
    check("j2_done", done, 1'b1);
    check("j2_result", result, 32'd24);
    tick();

`ifdef CALC_TIMEOUT_EN
    // No matching store: watchdog ends the job after exactly TO RUN cycles.
    start = 1'b1; op_a = 32'd1; op_b = 32'd2; opcode = 32'd4;
    tick();
    start = 1'b0;
    repeat (6) tick();
    repeat (TO - 1) tick();
    @(negedge clk);
    check("to_not_yet", done, 1'b0);
    tick();
    @(negedge clk);
    check("to_done", done, 1'b1);
    check("to_flag", timeout, 1'b1);
    check("to_result_kept", result, 32'd24);
    tick();
`endif

    // Start pulse while busy is ignored; start held through FIN relaunches.
    start = 1'b1; op_a = 32'd2; op_b = 32'd3; opcode = 32'd1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; op_a = 32'd99;
    tick();
    start = 1'b0;
    @(negedge clk);
    check("busy_start_ignored_addr", mem_addr, 32'h8);
    check("busy_start_ignored_data", mem_wdata, 32'd1);
    repeat (4) tick();
    cpu_wr(RA, 32'd77);
    start = 1'b1; op_a = 32'd55;
    tick();
    cpu_idle();
    @(negedge clk);
    check("hold_fin_done", done, 1'b1);
    tick();
    @(negedge clk);
    check("hold_idle", busy, 1'b0);
    tick();
    start = 1'b0;
    @(negedge clk);
    check("relaunch_busy", busy, 1'b1);
    check("relaunch_timeout", timeout, 1'b0);
    check("relaunch_addr0", mem_wdata, 32'd55);
    repeat (6) tick();
    cpu_wr(RA, 32'd5);
    tick();
    cpu_idle();
    tick();

    // Reset in the third LOAD cycle, then a clean restart.
    start = 1'b1; op_a = 32'd7; op_b = 32'd8; opcode = 32'd9;
    tick();
    start = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check("l3_addr", mem_addr, 32'h8);
    check("l3_data", mem_wdata, 32'd9);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_we", mem_we, 1'b0);
    check("mid_rst_cpu_reset", cpu_reset, 1'b1);
    start = 1'b1; op_a = 32'd33;
    tick();
    start = 1'b0;
    @(negedge clk);
    check("restart_addr", mem_addr, 32'h0);
    check("restart_data", mem_wdata, 32'd33);
    repeat (6) tick();
    cpu_wr(RA, 32'd40);
    tick();
    cpu_idle();
    tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      reset  = ($urandom_range(0, 79) == 0);
      start  = ($urandom_range(0, 2) == 0);
      op_a   = $urandom;
      op_b   = $urandom;
      opcode = $urandom_range(0, 5);
      cpu_memwrite = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 4))
        0:       cpu_addr = 32'h0;
        1:       cpu_addr = 32'h4;
        2:       cpu_addr = 32'h8;
        3:       cpu_addr = RA;
        default: cpu_addr = $urandom;
      endcase
      cpu_wdata = $urandom;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
